// File: rtl/event_readout_sequencer_if.sv
// FIFO write-port bundle between the event readout sequencer and the readout FIFO.
interface event_readout_sequencer_if;
    logic [15:0] fifo_din;
    logic        fifo_wr_en;
    logic        fifo_afull;

    modport master (output fifo_din, output fifo_wr_en, input fifo_afull);
    modport slave  (input fifo_din, input fifo_wr_en, output fifo_afull);
endinterface

// File: rtl/event_readout_sequencer.sv
// Sequences one coincidence event from the tube channels into the readout FIFO.
// Optional ZERO_SUPPRESS_EN: skip tubes whose hit time is zero (stop word still written).
module event_readout_sequencer #(
    parameter int          NUM_TUBES     = 32,
    parameter int          WINDOW_CYCLES = 256,
    parameter int          CLR_CYCLES    = 11,
    parameter logic [15:0] STOP_WORD     = 16'hFFFF
) (
    input  logic                   clk50,
    input  logic                   rst,
    input  logic                   scin_coin,
    input  logic [8*NUM_TUBES-1:0] tube_data,
    event_readout_sequencer_if.master fifo,
    output logic                   clr,
    output logic                   busy,
    output logic [7:0]             missed_cnt
);

    localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int IDX_W = ($clog2(NUM_TUBES) > 5) ? $clog2(NUM_TUBES) : 5;
    localparam int CLR_W = $clog2(CLR_CYCLES + 1);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TUBES - 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES);

    typedef enum logic [2:0] {IDLE, WINDOW, READOUT, STOP, CLEAR} state_t;

    state_t           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CLR_W-1:0] clrc_q, clrc_d;
    logic [15:0]      din_q, din_d;
    logic             wr_q, wr_d;
    logic             clr_q, clr_d;
    logic             busy_q, busy_d;
    logic [7:0]       missed_q, missed_d;
    logic [7:0]       slice;

    // Name byte: [7:5] position, [4] A/B half, [3:0] layer 3 or 4.
    function automatic logic [7:0] tube_name(input logic [IDX_W-1:0] i);
        return {i[2:0], i[3], 4'd3 + {3'b000, i[4]}};
    endfunction

    assign slice = tube_data[{idx_q, 3'b000} +: 8];

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        idx_d    = idx_q;
        clrc_d   = clrc_q;
        din_d    = din_q;
        wr_d     = 1'b0;
        clr_d    = clr_q;
        busy_d   = busy_q;
        missed_d = missed_q;

        if (scin_coin && state_q != IDLE && missed_q != 8'hFF)
            missed_d = missed_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (scin_coin) begin
                    state_d = WINDOW;
                    win_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            WINDOW: begin
                if (win_q == WIN_LAST) begin
                    state_d = READOUT;
                    idx_d   = '0;
                end else begin
                    win_d = win_q + 1'b1;
                end
            end
            READOUT: begin
`ifdef ZERO_SUPPRESS_EN
                // Empty channels advance without a write, whatever the FIFO level.
                if (slice == 8'd0 || !fifo.fifo_afull) begin
                    if (slice != 8'd0) begin
                        din_d = {slice, tube_name(idx_q)};
                        wr_d  = 1'b1;
                    end
                    if (idx_q == IDX_LAST) state_d = STOP;
                    else                   idx_d   = idx_q + 1'b1;
                end
`else
                if (!fifo.fifo_afull) begin
                    din_d = {slice, tube_name(idx_q)};
                    wr_d  = 1'b1;
                    if (idx_q == IDX_LAST) state_d = STOP;
                    else                   idx_d   = idx_q + 1'b1;
                end
`endif
            end
            STOP: begin
                if (!fifo.fifo_afull) begin
                    din_d   = STOP_WORD;
                    wr_d    = 1'b1;
                    state_d = CLEAR;
                    clrc_d  = '0;
                end
            end
            CLEAR: begin
                // clr is raised one cycle after the stop word and held CLR_CYCLES cycles.
                if (clrc_q == CLR_LAST) begin
                    clr_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    clr_d  = 1'b1;
                    clrc_d = clrc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk50) begin
        if (rst) begin
            state_q  <= IDLE;
            win_q    <= '0;
            idx_q    <= '0;
            clrc_q   <= '0;
            din_q    <= '0;
            wr_q     <= 1'b0;
            clr_q    <= 1'b0;
            busy_q   <= 1'b0;
            missed_q <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            idx_q    <= idx_d;
            clrc_q   <= clrc_d;
            din_q    <= din_d;
            wr_q     <= wr_d;
            clr_q    <= clr_d;
            busy_q   <= busy_d;
            missed_q <= missed_d;
        end
    end

    assign fifo.fifo_din   = din_q;
    assign fifo.fifo_wr_en = wr_q;
    assign clr             = clr_q;
    assign busy            = busy_q;
    assign missed_cnt      = missed_q;

endmodule

// File: tb/tb_event_readout_sequencer.sv
// Directed scoreboard bench for event_readout_sequencer (also builds with ZERO_SUPPRESS_EN).
module tb_event_readout_sequencer;

    localparam int NT = 32;
    localparam int W  = 256;
    localparam int C  = 11;

    logic            clk50 = 1'b0;
    logic            rst = 1'b1;
    logic            scin_coin = 1'b0;
    logic [8*NT-1:0] tube_data = '0;
    logic            clr;
    logic            busy;
    logic [7:0]      missed_cnt;

    event_readout_sequencer_if fifo ();

    event_readout_sequencer #(
        .NUM_TUBES(NT), .WINDOW_CYCLES(W), .CLR_CYCLES(C), .STOP_WORD(16'hFFFF)
    ) dut (
        .clk50(clk50), .rst(rst), .scin_coin(scin_coin), .tube_data(tube_data),
        .fifo(fifo), .clr(clr), .busy(busy), .missed_cnt(missed_cnt)
    );

    always #10 clk50 = ~clk50;

    int          cyc = 0;
    int          base = 0;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_q[$];
    int          wr_log[$];
    int          clr_first = -1;
    int          clr_last = -1;
    logic [7:0]  tube_v [NT];
    logic [15:0] mon_exp;

    always @(posedge clk50) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference name byte, written from the position/half/layer description.
    function automatic logic [7:0] name_of(input int i);
        logic [4:0] b;
        b = i[4:0];
        return {b[2:0], b[3], (b[4] ? 4'd4 : 4'd3)};
    endfunction

    task automatic step();
        @(posedge clk50);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc - base < c) step();
    endtask

    task automatic fill_random();
        for (int i = 0; i < NT; i++) tube_v[i] = 8'($urandom_range(1, 255));
    endtask

    // Drive the tube data, queue the expected words, and pulse scin_coin (cycle 0).
    task automatic start_event();
        bit keep;
        for (int i = 0; i < NT; i++) begin
            tube_data[8*i +: 8] = tube_v[i];
            keep = 1'b1;
`ifdef ZERO_SUPPRESS_EN
            keep = (tube_v[i] != 8'd0);
`endif
            if (keep) exp_q.push_back({tube_v[i], name_of(i)});
        end
        exp_q.push_back(16'hFFFF);
        wr_log.delete();
        clr_first = -1;
        clr_last  = -1;
        base      = cyc;
        scin_coin = 1'b1;
        step();
        scin_coin = 1'b0;
    endtask

    function automatic int log_at(input int k);
        return (k < wr_log.size()) ? wr_log[k] : -1;
    endfunction

    always @(negedge clk50) begin
        if (fifo.fifo_wr_en) begin
            wr_log.push_back(cyc - base);
            if (exp_q.size() == 0) begin
                check("write_without_expectation", {31'b0, fifo.fifo_wr_en}, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("fifo_word", {16'b0, fifo.fifo_din}, {16'b0, mon_exp});
            end
        end
        if (clr) begin
            if (clr_first < 0) clr_first = cyc - base;
            clr_last = cyc - base;
        end
    end

    initial begin
        int bad;
        fifo.fifo_afull = 1'b0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_clr", {31'b0, clr}, 32'd0);
        check("rst_wr_en", {31'b0, fifo.fifo_wr_en}, 32'd0);
        check("rst_din", {16'b0, fifo.fifo_din}, 32'd0);
        check("rst_missed", {24'b0, missed_cnt}, 32'd0);
        rst = 1'b0;
        step();

        // Event 1: single hit, no backpressure
        for (int i = 0; i < NT; i++) tube_v[i] = 8'h00;
`ifdef ZERO_SUPPRESS_EN
        tube_v[0]  = 8'h01;
        tube_v[31] = 8'h7F;
`else
        tube_v[5] = 8'h2A;
`endif
        start_event();
        check("e1_busy_rise", {31'b0, busy}, 32'd1);
        run_to(W);
        check("e1_window_no_write", {31'b0, fifo.fifo_wr_en}, 32'd0);
        run_to(W + 34 + C);
        check("e1_busy_last_clr", {30'b0, busy, clr}, 32'd3);
        run_to(W + 35 + C);
        check("e1_busy_fall", {30'b0, busy, clr}, 32'd0);
`ifdef ZERO_SUPPRESS_EN
        check("e1_word_count", wr_log.size(), 32'd3);
        check("e1_first_cycle", log_at(0), W + 2);
        check("e1_tube31_cycle", log_at(1), W + 33);
        check("e1_stop_cycle", log_at(2), W + 34);
`else
        check("e1_word_count", wr_log.size(), 32'd33);
        bad = 0;
        for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] != W + 2 + i) bad++;
        check("e1_contiguous", bad, 32'd0);
        check("e1_first_cycle", log_at(0), 32'd258);
        check("e1_stop_cycle", log_at(32), 32'd290);
`endif
        check("e1_clr_first", clr_first, W + 35);
        check("e1_clr_last", clr_last, W + 34 + C);
        check("e1_queue_drained", exp_q.size(), 32'd0);

        // Event 2: 5-cycle stall, missed pulses in WINDOW and CLEAR
        fill_random();
        start_event();
        run_to(5);
        scin_coin = 1'b1;
        run_to(8);
        scin_coin = 1'b0;
        run_to(W + 10);
        fifo.fifo_afull = 1'b1;
        run_to(W + 13);
        check("e2_stall_no_write", {31'b0, fifo.fifo_wr_en}, 32'd0);
        run_to(W + 15);
        fifo.fifo_afull = 1'b0;
        run_to(W + 45);
        scin_coin = 1'b1;
        step();
        scin_coin = 1'b0;
        run_to(W + 50);
        scin_coin = 1'b1;      // last clr cycle: IDLE re-entered, still counted as missed
        step();
        scin_coin = 1'b0;
        check("e2_missed", {24'b0, missed_cnt}, 32'd5);
        check("e2_idle", {30'b0, busy, clr}, 32'd0);
        check("e2_word_count", wr_log.size(), 32'd33);
        check("e2_before_gap", log_at(8), W + 10);
        check("e2_after_gap", log_at(9), W + 16);
        check("e2_stop_cycle", log_at(32), W + 39);
        check("e2_clr_first", clr_first, W + 40);
        check("e2_clr_last", clr_last, W + 50);

        // Event 3: accepted in first IDLE cycle, then aborted by reset
        fill_random();
        start_event();
        check("e3_accept_first_idle", {31'b0, busy}, 32'd1);
        run_to(W + 20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("e3_rst_outputs", {29'b0, fifo.fifo_wr_en, busy, clr}, 32'd0);
        check("e3_rst_missed", {24'b0, missed_cnt}, 32'd0);
        check("e3_words_before_rst", wr_log.size(), 32'd19);
        exp_q.delete();
        run_to(W + 80);
        check("e3_no_stop_word", wr_log.size(), 32'd19);
        check("e3_no_clr", clr_first, -1);

        // Event 4: full event after abort, scin held 300 cycles to saturate missed_cnt
        fill_random();
        start_event();
        scin_coin = 1'b1;
        run_to(201);
        check("e4_missed_200", {24'b0, missed_cnt}, 32'd200);
        run_to(301);
        scin_coin = 1'b0;
        check("e4_missed_sat", {24'b0, missed_cnt}, 32'd255);
        run_to(W + 35 + C);
        check("e4_busy_fall", {31'b0, busy}, 32'd0);
        check("e4_word_count", wr_log.size(), 32'd33);
        check("e4_first_cycle", log_at(0), W + 2);
        check("e4_stop_cycle", log_at(32), W + 34);
        check("e4_clr_first", clr_first, W + 35);
        check("e4_clr_last", clr_last, W + 34 + C);
        check("e4_queue_drained", exp_q.size(), 32'd0);
        step();
        check("e4_missed_hold", {24'b0, missed_cnt}, 32'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/event_readout_sequencer.md
# event_readout_sequencer

Controller that sequences one coincidence event from the 32 tube timing channels into the 16-bit readout FIFO. Opens a fixed acquisition window on `scin_coin`, scans every tube channel in a fixed order, writes one tagged word per tube plus a stop word, then pulses `clr` to re-arm the tube front-ends and scintillator latch. Sits between the `Tube` instances and the FIFO write port in the `clk50` domain. Replaces ad-hoc counter decoding with an explicit FSM that honours FIFO backpressure.

## Interface
- `NUM_TUBES`, 32, tube channels scanned; index i maps to `tube_data[8*i+7:8*i]`.
- `WINDOW_CYCLES`, 256, acquisition window length in `clk50` cycles (≥2).
- `CLR_CYCLES`, 11, `clr` pulse width in cycles (≥1).
- `STOP_WORD`, 16'hFFFF, end-of-event marker.

Ports:
- `clk50` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `scin_coin` in 1: scintillator coincidence, already synchronous to `clk50`.
- `tube_data` in 8*NUM_TUBES: per-tube hit time in cycles; 0 = no hit.
- `fifo_afull` in 1: FIFO almost-full, high when ≤1 free location.
- `fifo_din` out 16: {tube time[15:8], tube name[7:0]}.
- `fifo_wr_en` out 1: FIFO write strobe.
- `clr` out 1: clear to tube front-ends and scintillator latch.
- `busy` out 1: high from event accept until `clr` drops.
- `missed_cnt` out 8: saturating count of coincidences ignored while busy.

## Operation
- Tube name for index i: `{i[2:0], i[3], 4'd3 + i[4]}`; i.e. [7:5] position, [4] A/B half, [3:0] layer 3 or 4. Index 0 → 8'h03, 15 → 8'hF3, 16 → 8'h04, 31 → 8'hF4.
- FSM states: IDLE, WINDOW, READOUT, STOP, CLEAR.
- IDLE: `scin_coin` high → WINDOW, window counter := 0, `busy` := 1.
- WINDOW: counter increments each cycle; after WINDOW_CYCLES cycles → READOUT, index := 0.
- READOUT: if `fifo_afull` low, launch word for current index, index++; if high, launch nothing, hold index (stall). After index NUM_TUBES-1 is launched → STOP.
- STOP: if `fifo_afull` low, launch STOP_WORD → CLEAR; else stall.
- CLEAR: `clr` high for exactly CLR_CYCLES cycles, then `clr`, `busy` := 0 → IDLE.
- `scin_coin` high in any state other than IDLE: ignored; `missed_cnt` += 1, saturating at 255. Edge-insensitive: each high cycle counts.
- `tube_data` is sampled at launch time; front-ends hold values until `clr`.
- `fifo_afull` must not deassert `fifo_wr_en` already launched; one word of slack is guaranteed by the afull threshold.

## Timing
- Reset: state IDLE; `fifo_din`=0, `fifo_wr_en`=0, `clr`=0, `busy`=0, `missed_cnt`=0, effective the cycle after `rst` sampled high. Reset mid-event aborts it: no further words, no stop word, no `clr` pulse.
- All outputs registered.
- `scin_coin` sampled high at cycle 0 → `busy`=1 at cycle 1; WINDOW occupies cycles 1..W (W=WINDOW_CYCLES).
- No backpressure: `fifo_wr_en` high cycles W+2..W+33 carrying tubes 0..31; STOP_WORD at W+34; `clr` high W+35..W+34+CLR_CYCLES; `busy` falls together with `clr`.
- Each stall cycle delays all subsequent words, stop word, and `clr` by one cycle; `fifo_wr_en` low during stall cycles.
- First cycle in IDLE after CLEAR accepts a new `scin_coin`.
- `scin_coin` high in the same cycle IDLE is re-entered (last `clr` cycle) counts as missed.

## Configuration
- `ZERO_SUPPRESS_EN` defined: in READOUT, tubes with `tube_data` slice == 0 are skipped without a write and consume one cycle each; stop word always written. Undefined: all NUM_TUBES words written regardless of value (default, fixed 33-word event).

## Test plan
- Single event, W=256, no afull, tube 5 = 8'h2A, others 0 → 33 writes at cycles 258..290; word 5 = 16'h2AA3; word 32 = 16'hFFFF; `clr` high 291..301.
- `fifo_afull` held high cycles W+10..W+14 → exactly 5-cycle gap; 33 words in order, no loss, no duplicate, stop word at W+39.
- `scin_coin` pulsed 3 cycles during WINDOW and 2 cycles during CLEAR → `missed_cnt`=5; only one event written; 300 pulses saturate at 255.
- `rst` high at cycle W+20 → `fifo_wr_en`, `busy`, `clr` low next cycle; no stop word; next `scin_coin` yields complete 33-word event.
- `ZERO_SUPPRESS_EN`, hits only on tubes 0 (8'h01) and 31 (8'h7F) → writes 16'h0103, 16'h7FF4, 16'hFFFF; `clr` rises after stop word.
